apb_operand_slave: RTL

APB_OPERAND_SLAVE -- requirements
Module: apb_operand_slave

---
 rtl/apb_operand_slave.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/apb_operand_slave.sv
// APB slave that loads and reads back operand banks A and B and drives the
// multiplier control register (START / BUSY / DONE).
//
// Handshake: a transfer is SETUP (psel=1, penable=0) followed by ACCESS
// (psel=1, penable=1). The slave always inserts one wait state, and pready_o
// is high only in the ACCESS cycle. Every response output (prdata_o,
// pslverr_o, write enables, start_o) is registered at the SETUP-to-ACCESS
// edge. These outputs are therefore non-zero only while pready_o is high.
module apb_operand_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int BUS_WIDTH  = 64,
    parameter int ADDR_WIDTH = 16,
    localparam int MAX_DIM   = BUS_WIDTH / DATA_WIDTH,
    localparam int ROW_W     = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic                  pwrite_i,
    input  logic [ADDR_WIDTH-1:0] paddr_i,
    input  logic [BUS_WIDTH-1:0]  pwdata_i,
    input  logic [MAX_DIM-1:0]    pstrb_i,
    output logic [BUS_WIDTH-1:0]  prdata_o,
    output logic                  pready_o,
    output logic                  pslverr_o,
    output logic                  op_we_a_o,
    output logic                  op_we_b_o,
    output logic [ROW_W-1:0]      op_addr_o,
    output logic [BUS_WIDTH-1:0]  op_data_o,
    output logic [MAX_DIM-1:0]    op_strb_o,
    input  logic [BUS_WIDTH-1:0]  op_rdata_a_i,
    input  logic [BUS_WIDTH-1:0]  op_rdata_b_i,
    output logic                  start_o,
    input  logic                  busy_i,
    input  logic                  done_i
);

    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_A    = 2'd1;
    localparam logic [1:0] REG_B    = 2'd2;

    state_t                 state_q, state_d;
    logic [1:0]             region_q;
    logic [ROW_W-1:0]       row_q;
    logic                   write_q;
    logic [BUS_WIDTH-1:0]   wdata_q;
    logic [MAX_DIM-1:0]     strb_q;
    logic [BUS_WIDTH-1:0]   rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic                   we_a_q, we_a_d;
    logic                   we_b_q, we_b_d;
    logic                   start_q, start_d;
    logic                   done_q, done_d;
    logic [BUS_WIDTH-1:0]   ctrl_rd;
    logic                   capture;
    logic                   respond;
    logic                   done_clear;
    logic                   unused_addr;

    // Only region and row bits of the address are decoded.
    assign unused_addr = ^paddr_i;

    assign capture    = (state_q == IDLE) && psel_i && !penable_i;
    assign respond    = (state_q == SETUP) && psel_i && penable_i;
    // A rejected CTRL write (START while busy) has no side effects at all.
    assign done_clear = (state_q == ACCESS) && (region_q == REG_CTRL) && write_q
                        && wdata_q[2] && !err_q;

    // State register plus captured request and registered response.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            region_q <= '0;
            row_q    <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            we_a_q   <= 1'b0;
            we_b_q   <= 1'b0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                region_q <= paddr_i[7:6];
                row_q    <= paddr_i[2+ROW_W:3];
                write_q  <= pwrite_i;
                wdata_q  <= pwdata_i;
                strb_q   <= pstrb_i;
            end
            rdata_q <= rdata_d;
            err_q   <= err_d;
            we_a_q  <= we_a_d;
            we_b_q  <= we_b_d;
            start_q <= start_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: one SETUP cycle, one ACCESS cycle, abort back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (psel_i && !penable_i) state_d = SETUP;
            SETUP:   state_d = (psel_i && penable_i) ? ACCESS : IDLE;
            ACCESS:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // CTRL read view: START reads 0, BUSY mirrors busy_i, DONE is sticky.
    always_comb begin
        ctrl_rd    = '0;
        ctrl_rd[1] = busy_i;
        ctrl_rd[2] = done_q;
    end

    // Response decided at the SETUP-to-ACCESS edge; zero on every other edge.
    always_comb begin
        rdata_d = '0;
        err_d   = 1'b0;
        we_a_d  = 1'b0;
        we_b_d  = 1'b0;
        start_d = 1'b0;
        if (respond) begin
            case (region_q)
                REG_CTRL: begin
                    if (write_q) begin
                        if (wdata_q[0] && busy_i) err_d = 1'b1;
                        else                      start_d = wdata_q[0];
                    end else begin
                        rdata_d = ctrl_rd;
                    end
                end
                REG_A, REG_B: begin
                    if (write_q) begin
                        if (busy_i) begin
                            err_d = 1'b1;
                        end else if (|strb_q) begin
                            we_a_d = (region_q == REG_A);
                            we_b_d = (region_q == REG_B);
                        end
                    end else begin
                        rdata_d = (region_q == REG_A) ? op_rdata_a_i : op_rdata_b_i;
                    end
                end
                default: err_d = 1'b1;
            endcase
        end
    end

    // DONE is set by done_i, which wins over a coincident write-1-clear.
    always_comb begin
        done_d = done_q;
        if (done_i)          done_d = 1'b1;
        else if (done_clear) done_d = 1'b0;
    end

    // Output decode: the row is held from SETUP through ACCESS.
    always_comb begin
        pready_o  = (state_q == ACCESS);
        pslverr_o = err_q;
        prdata_o  = rdata_q;
        op_we_a_o = we_a_q;
        op_we_b_o = we_b_q;
        start_o   = start_q;
        op_addr_o = (state_q != IDLE) ? row_q : '0;
        op_data_o = (we_a_q || we_b_q) ? wdata_q : '0;
        op_strb_o = (we_a_q || we_b_q) ? strb_q : '0;
    end

endmodule
